// File: rtl/gppcu_fpu_arbiter.sv
// Round-robin arbiter that shares one multi-cycle FPU between the GPPCU thread lanes.
// Optional watchdog: define GPPCU_FPU_TIMEOUT_EN to retire a hung operation after TIMEOUT_CYC WAIT cycles.
module gppcu_fpu_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int DBW         = 32,
  parameter int OPW         = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       iACLK,
  input  logic                       iARESET,
  input  logic [NUM_THREADS-1:0]     iREQ,
  input  logic [NUM_THREADS*OPW-1:0] iOPCODE,
  input  logic [NUM_THREADS*DBW-1:0] iOPA,
  input  logic [NUM_THREADS*DBW-1:0] iOPB,
  output logic [NUM_THREADS-1:0]     oBUSY,
  output logic [NUM_THREADS-1:0]     oDONE,
  output logic [DBW-1:0]             oRESULT,
  output logic                       oFPU_START,
  output logic [OPW-1:0]             oFPU_OP,
  output logic [DBW-1:0]             oFPU_A,
  output logic [DBW-1:0]             oFPU_B,
  input  logic                       iFPU_DONE,
  input  logic [DBW-1:0]             iFPU_RESULT,
  output logic                       oERR
);

  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  if (NUM_THREADS < 2 || NUM_THREADS > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("gppcu_fpu_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_rr_ptr;
  logic [TW-1:0]   r_grant;
  logic [TW-1:0]   w_gidx;
  logic            w_found;
  logic            w_timeout;
  logic [OPW-1:0]  w_sel_op;
  logic [DBW-1:0]  w_sel_a;
  logic [DBW-1:0]  w_sel_b;
  logic [OPW-1:0]  r_op;
  logic [DBW-1:0]  r_a;
  logic [DBW-1:0]  r_b;
  logic [DBW-1:0]  r_result;

  // Round-robin search starting one past the last served thread.
  always_comb begin : arb
    int            v_idx;
    logic [TW-1:0] v_sel;
    w_found = 1'b0;
    w_gidx  = '0;
    v_idx   = 0;
    v_sel   = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_THREADS;
      v_sel = TW'(v_idx);
      if (!w_found && iREQ[v_sel]) begin
        w_found = 1'b1;
        w_gidx  = v_sel;
      end
    end
  end

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (w_gidx == TW'(i)) begin
        w_sel_op = iOPCODE[i*OPW +: OPW];
        w_sel_a  = iOPA[i*DBW +: DBW];
        w_sel_b  = iOPB[i*DBW +: DBW];
      end
    end
  end

`ifdef GPPCU_FPU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_err;

  // Counter sits at zero outside WAIT, so it starts clean on every WAIT entry.
  always_ff @(posedge iACLK or posedge iARESET) begin
    if (iARESET) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !iFPU_DONE &&
                     (r_tmo_cnt == CW'(TIMEOUT_CYC - 1));
  assign oERR      = r_err;
`else
  assign w_timeout = 1'b0;
  assign oERR      = 1'b0;
`endif

  always_ff @(posedge iACLK or posedge iARESET) begin
    if (iARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT:   if (iFPU_DONE || w_timeout) w_state_nxt = S_RETIRE;
      S_RETIRE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, operand latch and result capture.
  always_ff @(posedge iACLK or posedge iARESET) begin
    if (iARESET) begin
      r_rr_ptr <= TW'(NUM_THREADS - 1);
      r_grant  <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_gidx;
        r_op    <= w_sel_op;
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
      end
      if (r_state == S_WAIT) begin
        if (iFPU_DONE) begin
          r_result <= iFPU_RESULT;
        end else if (w_timeout) begin
          r_result <= '0;
        end
      end
      if (r_state == S_RETIRE) begin
        r_rr_ptr <= r_grant;
      end
    end
  end

  always_comb begin
    oDONE = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      oDONE[i] = (r_state == S_RETIRE) && (r_grant == TW'(i));
    end
  end

  assign oBUSY      = iREQ & ~oDONE;
  assign oFPU_START = (r_state == S_ISSUE);
  assign oFPU_OP    = r_op;
  assign oFPU_A     = r_a;
  assign oFPU_B     = r_b;
  assign oRESULT    = r_result;

endmodule

// File: tb/tb_gppcu_fpu_arbiter.sv
// Directed bench for gppcu_fpu_arbiter in its default build (watchdog disabled).
module tb_gppcu_fpu_arbiter;

  logic         iACLK = 1'b0;
  logic         iARESET;
  logic [3:0]   iREQ;
  logic [15:0]  iOPCODE;
  logic [127:0] iOPA;
  logic [127:0] iOPB;
  logic [3:0]   oBUSY;
  logic [3:0]   oDONE;
  logic [31:0]  oRESULT;
  logic         oFPU_START;
  logic [3:0]   oFPU_OP;
  logic [31:0]  oFPU_A;
  logic [31:0]  oFPU_B;
  logic         iFPU_DONE;
  logic [31:0]  iFPU_RESULT;
  logic         oERR;

  int total = 0;
  int bad   = 0;

  gppcu_fpu_arbiter #(
    .NUM_THREADS(4),
    .DBW(32),
    .OPW(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .iACLK(iACLK),
    .iARESET(iARESET),
    .iREQ(iREQ),
    .iOPCODE(iOPCODE),
    .iOPA(iOPA),
    .iOPB(iOPB),
    .oBUSY(oBUSY),
    .oDONE(oDONE),
    .oRESULT(oRESULT),
    .oFPU_START(oFPU_START),
    .oFPU_OP(oFPU_OP),
    .oFPU_A(oFPU_A),
    .oFPU_B(oFPU_B),
    .iFPU_DONE(iFPU_DONE),
    .iFPU_RESULT(iFPU_RESULT),
    .oERR(oERR)
  );

  always #5 iACLK = ~iACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge iACLK);
    #2;
  endtask

  task automatic do_reset();
    iARESET     = 1'b1;
    iREQ        = '0;
    iFPU_DONE   = 1'b0;
    iFPU_RESULT = '0;
    nxt();
    nxt();
    iARESET = 1'b0;
  endtask

  initial begin
    int g;
    logic [3:0] rem;
    logic [3:0] gmask;
    int exp_g [4];
    exp_g = '{1, 3, 1, 3};

    iOPCODE = '0;
    iOPA    = '0;
    iOPB    = '0;
    do_reset();
    #1;
    chk("rst_done",   oDONE, 4'b0000);
    chk("rst_result", oRESULT, 32'h0);
    chk("rst_start",  oFPU_START, 1'b0);
    chk("rst_op",     oFPU_OP, 4'h0);
    chk("rst_a",      oFPU_A, 32'h0);
    chk("rst_b",      oFPU_B, 32'h0);
    chk("rst_err",    oERR, 1'b0);
    chk("rst_busy",   oBUSY, 4'b0000);

    // Single request from thread 2, FPU latency 3.
    iREQ = 4'b0100;
    iOPCODE[8 +: 4] = 4'h1;
    iOPA[64 +: 32]  = 32'h3F800000;
    iOPB[64 +: 32]  = 32'h40000000;
    #1;
    chk("t1_busy_c0", oBUSY, 4'b0100);
    chk("t1_start_c0", oFPU_START, 1'b0);
    nxt();
    chk("t1_start_c1", oFPU_START, 1'b1);
    chk("t1_op", oFPU_OP, 4'h1);
    chk("t1_a", oFPU_A, 32'h3F800000);
    chk("t1_b", oFPU_B, 32'h40000000);
    nxt();
    chk("t1_start_c2", oFPU_START, 1'b0);
    nxt();
    nxt();
    iFPU_DONE   = 1'b1;
    iFPU_RESULT = 32'h40400000;
    #1;
    chk("t1_busy_c4", oBUSY, 4'b0100);
    chk("t1_done_c4", oDONE, 4'b0000);
    nxt();
    iFPU_DONE = 1'b0;
    #1;
    chk("t1_done_c5", oDONE, 4'b0100);
    chk("t1_result", oRESULT, 32'h40400000);
    chk("t1_busy_c5", oBUSY, 4'b0000);
    iREQ = 4'b0000;
    nxt();
    chk("t1_done_c6", oDONE, 4'b0000);
    chk("t1_result_hold", oRESULT, 32'h40400000);

    // All four threads at once, latency 1: grants 0,1,2,3 with oDONE at 3,7,11,15.
    for (int t = 0; t < 4; t++) begin
      iOPCODE[t*4 +: 4] = 4'(t + 2);
      iOPA[t*32 +: 32]  = 32'hA0000000 + 32'(t);
      iOPB[t*32 +: 32]  = 32'hB0000000 + 32'(t);
    end
    do_reset();
    iREQ = 4'b1111;
    rem  = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      gmask = 4'(1 << t);
      #1;
      chk("t2_busy_idle", oBUSY, rem);
      chk("t2_start_idle", oFPU_START, 1'b0);
      nxt();
      chk("t2_start", oFPU_START, 1'b1);
      chk("t2_op", oFPU_OP, 4'(t + 2));
      chk("t2_a", oFPU_A, 32'hA0000000 + 32'(t));
      chk("t2_b", oFPU_B, 32'hB0000000 + 32'(t));
      nxt();
      iFPU_DONE   = 1'b1;
      iFPU_RESULT = 32'hC0000000 + 32'(t);
      nxt();
      iFPU_DONE = 1'b0;
      #1;
      chk("t2_done", oDONE, gmask);
      chk("t2_result", oRESULT, 32'hC0000000 + 32'(t));
      chk("t2_busy_retire", oBUSY, rem & ~gmask);
      rem  = rem & ~gmask;
      iREQ = rem;
      nxt();
    end

    // Fairness: threads 1 and 3 keep requesting; grants must alternate.
    do_reset();
    iREQ = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      g     = exp_g[n];
      gmask = 4'(1 << g);
      #1;
      chk("t3_start_idle", oFPU_START, 1'b0);
      nxt();
      chk("t3_grant_a", oFPU_A, 32'hA0000000 + 32'(g));
      nxt();
      iFPU_DONE   = 1'b1;
      iFPU_RESULT = 32'hD0000000 + 32'(n);
      nxt();
      iFPU_DONE = 1'b0;
      #1;
      chk("t3_done", oDONE, gmask);
      chk("t3_result", oRESULT, 32'hD0000000 + 32'(n));
      chk("t3_busy", oBUSY, 4'b1010 & ~gmask);
      nxt();
    end
    iREQ = 4'b0000;

    // Reset in WAIT, then a stray FPU done must not produce a completion.
    do_reset();
    iREQ = 4'b0001;
    nxt();
    chk("t4_start", oFPU_START, 1'b1);
    nxt();
    iARESET = 1'b1;
    #1;
    chk("t4_rst_start", oFPU_START, 1'b0);
    chk("t4_rst_a", oFPU_A, 32'h0);
    iREQ = 4'b0000;
    nxt();
    iARESET = 1'b0;
    nxt();
    iFPU_DONE   = 1'b1;
    iFPU_RESULT = 32'hEEEEEEEE;
    nxt();
    iFPU_DONE = 1'b0;
    #1;
    chk("t4_stray_done", oDONE, 4'b0000);
    chk("t4_stray_start", oFPU_START, 1'b0);
    nxt();
    chk("t4_stray_done2", oDONE, 4'b0000);
    chk("t4_stray_result", oRESULT, 32'h0);
    iREQ = 4'b0001;
    nxt();
    chk("t4_re_start", oFPU_START, 1'b1);
    chk("t4_re_a", oFPU_A, 32'hA0000000);
    nxt();
    iFPU_DONE   = 1'b1;
    iFPU_RESULT = 32'h12345678;
    nxt();
    iFPU_DONE = 1'b0;
    #1;
    chk("t4_re_done", oDONE, 4'b0001);
    chk("t4_re_result", oRESULT, 32'h12345678);
    iREQ = 4'b0000;
    nxt();

    // Thread 1 pulses its request while thread 0 is in flight and is never served.
    do_reset();
    iREQ = 4'b0001;
    nxt();
    iREQ = 4'b0011;
    #1;
    chk("t5_busy_pulse", oBUSY, 4'b0011);
    nxt();
    iREQ = 4'b0001;
    nxt();
    iFPU_DONE   = 1'b1;
    iFPU_RESULT = 32'h00000055;
    nxt();
    iFPU_DONE = 1'b0;
    #1;
    chk("t5_done0", oDONE, 4'b0001);
    iREQ = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      nxt();
      chk("t5_no_done", oDONE, 4'b0000);
      chk("t5_no_start", oFPU_START, 1'b0);
    end
    chk("t5_err", oERR, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
